zap_regf_lvt_multiport: RTL and testbench

Parametrised two-write / N-read register file for the ZAP core, built from two write banks plus a live-value table (LVT) that tracks which bank holds the current value of each entry. It generalises the fixed 40x32, four-read-port flip-flop register file with:
- width, depth and read-port count as parameters;
- independent per-port write enables and a defined collision rule;
- a post-reset hardware clear sequencer;
- optional write-to-read bypass.

It sits between decode (read addresses) and writeback (two write ports) in the core clock domain.

---
 rtl/zap_regf_lvt_multiport.sv | 120 ++++++++++++
 tb/tb_zap_regf_lvt_multiport.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/zap_regf_lvt_multiport.sv
// Two-write / NRD-read register file: two write banks plus a live-value table,
// with a post-reset clear sequencer. Define ZAP_REGF_BYPASS_EN for write-to-read bypass.
module zap_regf_lvt_multiport #(
    parameter int DW    = 32,
    parameter int DEPTH = 40,
    parameter int AW    = 6,
    parameter int NRD   = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wen_a,
    input  logic [AW-1:0]     i_wr_addr_a,
    input  logic [DW-1:0]     i_wr_data_a,
    input  logic              i_wen_b,
    input  logic [AW-1:0]     i_wr_addr_b,
    input  logic [DW-1:0]     i_wr_data_b,
    input  logic [NRD*AW-1:0] i_rd_addr,
    output logic [NRD*DW-1:0] o_rd_data,
    output logic              o_ready,
    output logic              o_collision
);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t          state;
    logic [AW-1:0]   clr_idx;

    logic [DW-1:0]   bank_a [DEPTH];
    logic [DW-1:0]   bank_b [DEPTH];
    logic [DEPTH-1:0] lvt;

    logic a_valid;
    logic b_valid;
    logic clr_we;
    logic wa_ok;
    logic wb_ok;

    assign a_valid = ({1'b0, i_wr_addr_a} < DEPTH_W);
    assign b_valid = ({1'b0, i_wr_addr_b} < DEPTH_W);

    // Writes presented during reset or during the clear sequence never commit.
    assign clr_we = (state == S_CLEAR) && !i_reset;
    assign wa_ok  = (state == S_RUN) && !i_reset && i_wen_a && a_valid;
    assign wb_ok  = (state == S_RUN) && !i_reset && i_wen_b && b_valid;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= S_CLEAR;
            clr_idx     <= '0;
            o_ready     <= 1'b0;
            o_collision <= 1'b0;
        end else begin
            o_collision <= wa_ok && wb_ok && (i_wr_addr_a == i_wr_addr_b);
            case (state)
                S_CLEAR: begin
                    if (clr_idx == LAST_IDX) begin
                        state   <= S_RUN;
                        o_ready <= 1'b1;
                    end else begin
                        clr_idx <= clr_idx + AW'(1);
                    end
                end
                default: begin
                    state   <= S_RUN;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

    // Bank B is never cleared: a zero LVT bit keeps it unreachable until port B rewrites the entry.
    always_ff @(posedge i_clk) begin
        if (clr_we) begin
            bank_a[clr_idx] <= '0;
            lvt[clr_idx]    <= 1'b0;
        end else begin
            if (wa_ok) begin
                bank_a[i_wr_addr_a] <= i_wr_data_a;
                lvt[i_wr_addr_a]    <= 1'b0;
            end
            // Ordered after port A so a same-address collision leaves port B current.
            if (wb_ok) begin
                bank_b[i_wr_addr_b] <= i_wr_data_b;
                lvt[i_wr_addr_b]    <= 1'b1;
            end
        end
    end

    genvar k;
    generate
        for (k = 0; k < NRD; k++) begin : g_rd
            logic [AW-1:0] ra;
            logic          ra_valid;
            logic [DW-1:0] rd_word;

            assign ra       = i_rd_addr[k*AW +: AW];
            assign ra_valid = ({1'b0, ra} < DEPTH_W);

            always_comb begin
                rd_word = '0;
                if ((state == S_RUN) && ra_valid) begin
                    rd_word = lvt[ra] ? bank_b[ra] : bank_a[ra];
`ifdef ZAP_REGF_BYPASS_EN
                    if (wa_ok && (i_wr_addr_a == ra)) rd_word = i_wr_data_a;
                    if (wb_ok && (i_wr_addr_b == ra)) rd_word = i_wr_data_b;
`endif
                end
            end

            assign o_rd_data[k*DW +: DW] = rd_word;
        end
    endgenerate

endmodule

// File: tb/tb_zap_regf_lvt_multiport.sv
// Directed bench for zap_regf_lvt_multiport: driver pushes expectations per cycle,
// a negedge monitor pops and compares them against the outputs of that cycle.
module tb_zap_regf_lvt_multiport;

    localparam int DW    = 32;
    localparam int DEPTH = 40;
    localparam int AW    = 6;
    localparam int NRD   = 4;
`ifdef ZAP_REGF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int K_RD    = 0;
    localparam int K_READY = 1;
    localparam int K_COLL  = 2;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              i_wen_a;
    logic [AW-1:0]     i_wr_addr_a;
    logic [DW-1:0]     i_wr_data_a;
    logic              i_wen_b;
    logic [AW-1:0]     i_wr_addr_b;
    logic [DW-1:0]     i_wr_data_b;
    logic [NRD*AW-1:0] i_rd_addr;
    logic [NRD*DW-1:0] o_rd_data;
    logic              o_ready;
    logic              o_collision;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] exp_q [$];
    int            kind_q[$];
    int            port_q[$];
    string         tag_q [$];

    zap_regf_lvt_multiport #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .NRD(NRD)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_wen_a     (i_wen_a),
        .i_wr_addr_a (i_wr_addr_a),
        .i_wr_data_a (i_wr_data_a),
        .i_wen_b     (i_wen_b),
        .i_wr_addr_b (i_wr_addr_b),
        .i_wr_data_b (i_wr_data_b),
        .i_rd_addr   (i_rd_addr),
        .o_rd_data   (o_rd_data),
        .o_ready     (o_ready),
        .o_collision (o_collision)
    );

    always #5 i_clk = ~i_clk;

    // Monitor: compare everything queued for the current cycle at the falling edge.
    initial begin
        logic [DW-1:0] want;
        logic [DW-1:0] got;
        int            kd;
        int            pt;
        string         tg;
        forever begin
            @(negedge i_clk);
            while (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                kd   = kind_q.pop_front();
                pt   = port_q.pop_front();
                tg   = tag_q.pop_front();
                case (kd)
                    K_RD:    got = o_rd_data[pt*DW +: DW];
                    K_READY: got = {{(DW-1){1'b0}}, o_ready};
                    default: got = {{(DW-1){1'b0}}, o_collision};
                endcase
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL %s port%0d: got %h want %h (t=%0t)", tg, pt, got, want, $time);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_wen_a     = 1'b0;
        i_wr_addr_a = '0;
        i_wr_data_a = '0;
        i_wen_b     = 1'b0;
        i_wr_addr_b = '0;
        i_wr_data_b = '0;
    endtask

    task automatic push(input int kd, input int pt, input logic [DW-1:0] v, input string tg);
        exp_q.push_back(v);
        kind_q.push_back(kd);
        port_q.push_back(pt);
        tag_q.push_back(tg);
    endtask

    task automatic set_rd(input int pt, input int addr);
        i_rd_addr[pt*AW +: AW] = AW'(addr);
    endtask

    task automatic rd_all(input int addr, input logic [DW-1:0] v, input string tg);
        for (int p = 0; p < NRD; p++) begin
            set_rd(p, addr);
            push(K_RD, p, v, tg);
        end
    endtask

    task automatic wr_a(input int addr, input logic [DW-1:0] d);
        i_wen_a = 1'b1; i_wr_addr_a = AW'(addr); i_wr_data_a = d;
    endtask

    task automatic wr_b(input int addr, input logic [DW-1:0] d);
        i_wen_b = 1'b1; i_wr_addr_b = AW'(addr); i_wr_data_b = d;
    endtask

    // One reset cycle, leaving the bench at clear cycle 0.
    task automatic do_reset();
        i_reset = 1'b1;
        cyc();
        i_reset = 1'b0;
    endtask

    // Full clear walk: ready low for DEPTH cycles, all reads zero throughout; optional junk writes.
    task automatic clear_walk(input bit junk);
        for (int c = 0; c < DEPTH + 2; c++) begin
            idle();
            if (junk && c < DEPTH) begin
                wr_a(3, 32'hDEAD_0000 + DW'(c));
                wr_b(3, 32'hBEEF_0000 + DW'(c));
            end
            for (int p = 0; p < NRD; p++) begin
                set_rd(p, (c + p * 11) % DEPTH);
                push(K_RD, p, '0, "clear_rd");
            end
            if (junk) set_rd(0, 3);
            push(K_READY, 0, DW'(c >= DEPTH), "ready");
            if (c > 0) push(K_COLL, 0, '0, "coll_clear");
            cyc();
        end
    endtask

    initial begin
        i_reset   = 1'b1;
        i_rd_addr = '0;
        idle();
        cyc();
        cyc();
        i_reset = 1'b0;

        // Power-on clear.
        push(K_COLL, 0, '0, "coll_reset");
        clear_walk(1'b0);

        // A then B to the same address on consecutive cycles.
        wr_a(3, 32'hA5A5_A5A5);
        rd_all(3, BYP ? 32'hA5A5_A5A5 : 32'h0, "a_then_b_c0");
        cyc();
        idle();
        wr_b(3, 32'h1234_5678);
        rd_all(3, BYP ? 32'h1234_5678 : 32'hA5A5_A5A5, "a_then_b_c1");
        push(K_COLL, 0, '0, "coll_ab");
        cyc();
        idle();
        rd_all(3, 32'h1234_5678, "a_then_b_c2");
        cyc();

        // Same-address collision: port B wins, one-cycle pulse.
        wr_a(7, 32'h1);
        wr_b(7, 32'h2);
        rd_all(7, BYP ? 32'h2 : 32'h0, "coll_c0");
        push(K_COLL, 0, '0, "coll_pre");
        cyc();
        idle();
        rd_all(7, 32'h2, "coll_c1");
        push(K_COLL, 0, 32'h1, "coll_pulse");
        cyc();
        set_rd(1, 3);
        push(K_RD, 0, 32'h2, "coll_c2");
        push(K_RD, 1, 32'h1234_5678, "coll_c2_other");
        push(K_COLL, 0, '0, "coll_end");
        cyc();

        // Out-of-range address: dropped, reads zero, no collision.
        wr_a(45, 32'hFFFF_FFFF);
        wr_b(45, 32'hFFFF_FFFF);
        set_rd(0, 45); push(K_RD, 0, '0, "oob_c0");
        set_rd(1, 3);  push(K_RD, 1, 32'h1234_5678, "oob_keep3");
        cyc();
        idle();
        set_rd(0, 45); push(K_RD, 0, '0, "oob_c1");
        set_rd(1, 3);  push(K_RD, 1, 32'h1234_5678, "oob_keep3b");
        set_rd(2, 7);  push(K_RD, 2, 32'h2, "oob_keep7");
        set_rd(3, 0);  push(K_RD, 3, '0, "oob_keep0");
        push(K_COLL, 0, '0, "coll_oob");
        cyc();

        // Same-cycle read of a port B write.
        wr_b(9, 32'hCAFE_F00D);
        set_rd(2, 9); push(K_RD, 2, BYP ? 32'hCAFE_F00D : 32'h0, "byp_c0");
        set_rd(0, 3); push(K_RD, 0, 32'h1234_5678, "byp_other");
        cyc();
        idle();
        set_rd(2, 9); push(K_RD, 2, 32'hCAFE_F00D, "byp_c1");
        cyc();

        // Reset from RUN, junk writes during clear, reset again at clear cycle 20.
        do_reset();
        for (int c = 0; c < 20; c++) begin
            wr_a(7, 32'h5555_0000 + DW'(c));
            wr_b(9, 32'h6666_0000 + DW'(c));
            set_rd(0, 7); push(K_RD, 0, '0, "mid_rd7");
            set_rd(1, 9); push(K_RD, 1, '0, "mid_rd9");
            push(K_READY, 0, '0, "mid_ready");
            cyc();
        end
        wr_a(3, 32'h7777_7777);
        i_reset = 1'b1;
        push(K_READY, 0, '0, "rst_ready");
        cyc();
        i_reset = 1'b0;
        clear_walk(1'b1);

        // Nothing written before or during the clears survives.
        idle();
        set_rd(0, 3); push(K_RD, 0, '0, "post_rd3");
        set_rd(1, 7); push(K_RD, 1, '0, "post_rd7");
        set_rd(2, 9); push(K_RD, 2, '0, "post_rd9");
        set_rd(3, 0); push(K_RD, 3, '0, "post_rd0");
        push(K_READY, 0, 32'h1, "post_ready");
        cyc();

        cyc();
        cyc();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
